mux_l1: RTL and testbench

- Layer-1 serializer: the transmit-side counterpart of the layer-1 demux.
- Accepts four 8-bit lanes (data_0..data_3 with valid_0..valid_3), each presented at half rate.
- Drives two 8-bit lanes (data_00, data_11) at full rate on a single clock, clk_2f; the half-rate slot is tracked by an internal phase bit.
- Feeds the layer-1 demux directly, so demux(mux(x)) == x on valid words.

---
 rtl/mux_l1_pkg.sv | 13 +
 rtl/mux_l1_if.sv | 33 +++
 rtl/mux_l1_lane.sv | 71 +++++++
 rtl/mux_l1.sv | 71 +++++++
 tb/tb_mux_l1.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_l1_pkg.sv
// Shared layer-1 definitions: default lane width and the half-rate slot encoding.
// The demux side imports the same package so both ends agree on slot order.
package mux_l1_pkg;

  localparam int L1_WIDTH = 8;

  // PH_FIRST carries lanes 0/2, PH_SECOND carries lanes 1/3.
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

endpackage

// File: rtl/mux_l1_if.sv
// Slow-side inputs and fast-side outputs of the layer-1 serializer.
// master = upstream word source/sink, slave = the serializer itself.
interface mux_l1_if #(
  parameter int WIDTH = mux_l1_pkg::L1_WIDTH
);

  logic [WIDTH-1:0] data_0;
  logic [WIDTH-1:0] data_1;
  logic [WIDTH-1:0] data_2;
  logic [WIDTH-1:0] data_3;
  logic             valid_0;
  logic             valid_1;
  logic             valid_2;
  logic             valid_3;
  logic             sample_en;
  logic [WIDTH-1:0] data_00;
  logic [WIDTH-1:0] data_11;
  logic             valid_00;
  logic             valid_11;

  modport master (
    output data_0, data_1, data_2, data_3,
    output valid_0, valid_1, valid_2, valid_3,
    input  sample_en, data_00, data_11, valid_00, valid_11
  );

  modport slave (
    input  data_0, data_1, data_2, data_3,
    input  valid_0, valid_1, valid_2, valid_3,
    output sample_en, data_00, data_11, valid_00, valid_11
  );

endinterface

// File: rtl/mux_l1_lane.sv
// One fast lane: captures a pair of slow words on the PH_SECOND edge and
// emits slot A then slot B, forcing data to zero whenever its valid is low.
module mux_l1_lane
  import mux_l1_pkg::*;
#(
  parameter int WIDTH = L1_WIDTH
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  phase_e           phase_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic             valid_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic             valid_b_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] cap_data_a_q, cap_data_a_d;
  logic [WIDTH-1:0] cap_data_b_q, cap_data_b_d;
  logic             cap_valid_a_q, cap_valid_a_d;
  logic             cap_valid_b_q, cap_valid_b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] slot_data;
  logic             slot_valid;

  always_comb begin
    cap_data_a_d  = cap_data_a_q;
    cap_data_b_d  = cap_data_b_q;
    cap_valid_a_d = cap_valid_a_q;
    cap_valid_b_d = cap_valid_b_q;
    slot_data     = cap_data_a_q;
    slot_valid    = cap_valid_a_q;

    // The second-slot edge reads the old pair while loading the new one.
    if (phase_i == PH_SECOND) begin
      cap_data_a_d  = data_a_i;
      cap_data_b_d  = data_b_i;
      cap_valid_a_d = valid_a_i;
      cap_valid_b_d = valid_b_i;
      slot_data     = cap_data_b_q;
      slot_valid    = cap_valid_b_q;
    end

    valid_d = slot_valid;
    data_d  = slot_valid ? slot_data : '0;
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      cap_data_a_q  <= '0;
      cap_data_b_q  <= '0;
      cap_valid_a_q <= 1'b0;
      cap_valid_b_q <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
    end else begin
      cap_data_a_q  <= cap_data_a_d;
      cap_data_b_q  <= cap_data_b_d;
      cap_valid_a_q <= cap_valid_a_d;
      cap_valid_b_q <= cap_valid_b_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mux_l1.sv
// Layer-1 serializer: four half-rate lanes onto two full-rate lanes.
// Owns the phase flop; each fast lane is an independent mux_l1_lane.
module mux_l1
  import mux_l1_pkg::*;
#(
  parameter int WIDTH = L1_WIDTH
) (
  input  logic    clk_2f,
  input  logic    reset_L,
  mux_l1_if.slave l1_bus
);

  localparam int N_LANES = 2;

  phase_e           phase_q, phase_d;
  logic [WIDTH-1:0] lane_data_a [N_LANES];
  logic [WIDTH-1:0] lane_data_b [N_LANES];
  logic             lane_valid_a [N_LANES];
  logic             lane_valid_b [N_LANES];
  logic [WIDTH-1:0] lane_data [N_LANES];
  logic             lane_valid [N_LANES];

  // Fast lane 0 interleaves slow lanes 0/1, fast lane 1 interleaves 2/3.
  assign lane_data_a[0]  = l1_bus.data_0;
  assign lane_valid_a[0] = l1_bus.valid_0;
  assign lane_data_b[0]  = l1_bus.data_1;
  assign lane_valid_b[0] = l1_bus.valid_1;
  assign lane_data_a[1]  = l1_bus.data_2;
  assign lane_valid_a[1] = l1_bus.valid_2;
  assign lane_data_b[1]  = l1_bus.data_3;
  assign lane_valid_b[1] = l1_bus.valid_3;

  always_comb begin
    phase_d = (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      phase_q <= PH_FIRST;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Straight from the phase flop, so sample_en never glitches.
  assign l1_bus.sample_en = (phase_q == PH_SECOND);

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      mux_l1_lane #(
        .WIDTH(WIDTH)
      ) u_lane (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .phase_i   (phase_q),
        .data_a_i  (lane_data_a[gi]),
        .valid_a_i (lane_valid_a[gi]),
        .data_b_i  (lane_data_b[gi]),
        .valid_b_i (lane_valid_b[gi]),
        .data_o    (lane_data[gi]),
        .valid_o   (lane_valid[gi])
      );
    end
  endgenerate

  assign l1_bus.data_00  = lane_data[0];
  assign l1_bus.valid_00 = lane_valid[0];
  assign l1_bus.data_11  = lane_data[1];
  assign l1_bus.valid_11 = lane_valid[1];

endmodule

// File: tb/tb_mux_l1.sv
// Bench for mux_l1: directed and random slow words checked against a FIFO
// model of expected fast-lane slots, plus a behavioural demux loopback.
module tb_mux_l1;
  import mux_l1_pkg::*;

  localparam int W = L1_WIDTH;

  typedef struct packed {
    logic [W-1:0] d00;
    logic         v00;
    logic [W-1:0] d11;
    logic         v11;
  } out_t;

  logic clk_2f  = 1'b0;
  logic reset_L = 1'b1;
  int   tests   = 0;
  int   fails   = 0;

  out_t         exp_q[$];
  logic         model_phase = 1'b0;
  logic [W-1:0] in_d [4];
  logic [3:0]   in_v;
  logic [W-1:0] rx_d [4];
  logic         rx_v [4];
  logic [W-1:0] lb_d [4];

  mux_l1_if #(.WIDTH(W)) l1_bus ();

  mux_l1 #(.WIDTH(W)) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .l1_bus  (l1_bus)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3,
                       input logic [3:0] v);
    in_d[0] = d0; in_d[1] = d1; in_d[2] = d2; in_d[3] = d3; in_v = v;
    l1_bus.data_0  = d0;   l1_bus.data_1  = d1;
    l1_bus.data_2  = d2;   l1_bus.data_3  = d3;
    l1_bus.valid_0 = v[0]; l1_bus.valid_1 = v[1];
    l1_bus.valid_2 = v[2]; l1_bus.valid_3 = v[3];
  endtask

  task automatic drive_random();
    drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample_en"}, 32'(l1_bus.sample_en), 32'd0);
    check({tag, "_data_00"},   32'(l1_bus.data_00),   32'd0);
    check({tag, "_valid_00"},  32'(l1_bus.valid_00),  32'd0);
    check({tag, "_data_11"},   32'(l1_bus.data_11),   32'd0);
    check({tag, "_valid_11"},  32'(l1_bus.valid_11),  32'd0);
  endtask

  // One clock edge: the model pops the slot due on this edge and, on a
  // capture edge, queues the two slots of the presented word set.
  task automatic tick();
    out_t expv;
    out_t slot_a;
    out_t slot_b;
    logic captured;
    captured   = reset_L && model_phase;
    slot_a.d00 = in_v[0] ? in_d[0] : '0;  slot_a.v00 = in_v[0];
    slot_a.d11 = in_v[2] ? in_d[2] : '0;  slot_a.v11 = in_v[2];
    slot_b.d00 = in_v[1] ? in_d[1] : '0;  slot_b.v00 = in_v[1];
    slot_b.d11 = in_v[3] ? in_d[3] : '0;  slot_b.v11 = in_v[3];
    @(posedge clk_2f);
    #1;
    expv = '0;
    if (!reset_L) begin
      exp_q.delete();
      model_phase = 1'b0;
    end else begin
      if (exp_q.size() != 0) expv = exp_q.pop_front();
      if (captured) begin
        exp_q.push_back(slot_a);
        exp_q.push_back(slot_b);
      end
      model_phase = ~model_phase;
    end
    check("sample_en", 32'(l1_bus.sample_en), 32'(model_phase));
    check("data_00",   32'(l1_bus.data_00),   32'(expv.d00));
    check("valid_00",  32'(l1_bus.valid_00),  32'(expv.v00));
    check("data_11",   32'(l1_bus.data_11),   32'(expv.d11));
    check("valid_11",  32'(l1_bus.valid_11),  32'(expv.v11));
  endtask

  // Align to a sample_en cycle, present one word set, then scramble inputs.
  task automatic present(input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3,
                         input logic [3:0] v);
    if (model_phase == 1'b0) begin
      drive_random();
      tick();
    end
    drive(d0, d1, d2, d3, v);
    $display("[TB] word d0=%02h d1=%02h d2=%02h d3=%02h valid=%04b", d0, d1, d2, d3, v);
    tick();
    drive_random();
  endtask

  initial begin
    drive_random();

    // Asynchronous reset assertion clears outputs before any edge.
    #1 reset_L = 1'b0;
    #1 check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick();
    end
    check_zero("rst_hold");

    reset_L = 1'b1;
    check("rel_sample_en", 32'(l1_bus.sample_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rel_toggle", 32'(l1_bus.sample_en), 32'((i % 2) == 0));
    end

    // Full-valid burst, back-to-back.
    present(8'hff, 8'hee, 8'hdd, 8'hcc, 4'hf);
    tick();
    check("burst_d00_ff", 32'(l1_bus.data_00), 32'hff);
    check("burst_d11_dd", 32'(l1_bus.data_11), 32'hdd);
    present(8'haa, 8'hbb, 8'h99, 8'h88, 4'hf);
    check("burst_d00_ee", 32'(l1_bus.data_00), 32'hee);
    check("burst_d11_cc", 32'(l1_bus.data_11), 32'hcc);
    tick();
    check("burst_d00_aa", 32'(l1_bus.data_00), 32'haa);
    check("burst_d11_99", 32'(l1_bus.data_11), 32'h99);

    // Partial valid: only lanes 0 and 3.
    present(8'h11, 8'h22, 8'h33, 8'h77, 4'b1001);
    check("burst_d00_bb", 32'(l1_bus.data_00), 32'hbb);
    check("burst_d11_88", 32'(l1_bus.data_11), 32'h88);
    tick();
    check("part_a", {l1_bus.data_00, 7'd0, l1_bus.valid_00, l1_bus.data_11, 7'd0, l1_bus.valid_11},
          {8'h11, 8'd1, 8'h00, 8'd0});

    // All invalid with random data.
    present(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'b0000);
    check("part_b", {l1_bus.data_00, 7'd0, l1_bus.valid_00, l1_bus.data_11, 7'd0, l1_bus.valid_11},
          {8'h00, 8'd0, 8'h77, 8'd1});
    tick();
    check("inval_a", {l1_bus.data_00, 7'd0, l1_bus.valid_00, l1_bus.data_11, 7'd0, l1_bus.valid_11}, 32'd0);

    // Reset between the ff and ee slots: ee must never appear.
    present(8'hff, 8'hee, 8'hdd, 8'hcc, 4'hf);
    check("inval_b", {l1_bus.data_00, 7'd0, l1_bus.valid_00, l1_bus.data_11, 7'd0, l1_bus.valid_11}, 32'd0);
    tick();
    check("mid_ff", 32'(l1_bus.data_00), 32'hff);
    #3 reset_L = 1'b0;
    #1 check_zero("mid_rst");
    exp_q.delete();
    model_phase = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(8'hff, 8'hee, 8'hdd, 8'hcc, 4'hf);
      tick();
      check("mid_no_stale_v00", 32'(l1_bus.valid_00), 32'd0);
      check("mid_no_stale_v11", 32'(l1_bus.valid_11), 32'd0);
    end

    // Loopback through a behavioural demux: slot A/B pairs rebuild the lanes.
    lb_d[0] = 8'hff; lb_d[1] = 8'hee; lb_d[2] = 8'hdd; lb_d[3] = 8'hcc;
    present(lb_d[0], lb_d[1], lb_d[2], lb_d[3], 4'hf);
    tick();
    rx_d[0] = l1_bus.data_00; rx_v[0] = l1_bus.valid_00;
    rx_d[2] = l1_bus.data_11; rx_v[2] = l1_bus.valid_11;
    present(8'hbb, 8'haa, 8'h99, 8'h88, 4'hf);
    rx_d[1] = l1_bus.data_00; rx_v[1] = l1_bus.valid_00;
    rx_d[3] = l1_bus.data_11; rx_v[3] = l1_bus.valid_11;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("loop1_lane%0d_data", i), 32'(rx_d[i]), 32'(lb_d[i]));
      check($sformatf("loop1_lane%0d_valid", i), 32'(rx_v[i]), 32'd1);
    end
    lb_d[0] = 8'hbb; lb_d[1] = 8'haa; lb_d[2] = 8'h99; lb_d[3] = 8'h88;
    tick();
    rx_d[0] = l1_bus.data_00; rx_v[0] = l1_bus.valid_00;
    rx_d[2] = l1_bus.data_11; rx_v[2] = l1_bus.valid_11;
    tick();
    rx_d[1] = l1_bus.data_00; rx_v[1] = l1_bus.valid_00;
    rx_d[3] = l1_bus.data_11; rx_v[3] = l1_bus.valid_11;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("loop2_lane%0d_data", i), 32'(rx_d[i]), 32'(lb_d[i]));
      check($sformatf("loop2_lane%0d_valid", i), 32'(rx_v[i]), 32'd1);
    end

    // Random words with random per-lane valids.
    for (int n = 0; n < 40; n++) begin
      present(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
